// File: rtl/example_acc_requant.sv
// example_acc_requant
//   Streaming accumulate-and-requantize stage. Sums groups of N_TERMS signed
//   products into a wide accumulator, then rounds (half toward +inf), shifts
//   right by FRAC_SHIFT and narrows the sum to OUT_WIDTH bits. Results are
//   presented on a valid/ready port.
//
//   Optional feature macro: ACC_REQUANT_SAT_EN
//     defined   -> narrowed result is clamped to the signed OUT_WIDTH range and
//                  ovf latches on any clamp (sticky until reset)
//     undefined -> narrowed result wraps (two's complement); ovf stays 0
//
// Ports
//   ap_clk      in   sole clock, rising edge
//   ap_rst_n    in   asynchronous active-low reset
//   prod_data   in   signed product (PROD_WIDTH)
//   prod_valid  in   product present
//   prod_ready  out  stage can accept a product (from state and out_ready only)
//   out_data    out  requantized signed sum (OUT_WIDTH), registered
//   out_valid   out  out_data holds a complete result, registered
//   out_ready   in   downstream accepts the result
//   ovf         out  sticky clamp flag
module example_acc_requant #(
  parameter int PROD_WIDTH = 20,
  parameter int ACC_WIDTH  = 28,
  parameter int OUT_WIDTH  = 16,
  parameter int N_TERMS    = 8,
  parameter int FRAC_SHIFT = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ovf
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  // One guard bit above the accumulator so adding the rounding constant
  // cannot overflow.
  localparam int RW    = ACC_WIDTH + 1;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N_TERMS - 1);
  localparam logic signed [RW-1:0] HALF     = RW'(1) << (FRAC_SHIFT - 1);

`ifdef ACC_REQUANT_SAT_EN
  localparam logic signed [RW-1:0] OUT_MAX = (RW'(1) << (OUT_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] OUT_MIN = ~OUT_MAX;
`endif

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]         out_data_q, out_data_d;
  logic                         ovf_q, ovf_d;

  logic                         prod_xfer;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [RW-1:0]         s_ext;
  logic signed [RW-1:0]         r_full;
  logic [OUT_WIDTH-1:0]         narrow;
  logic                         clamp;

  assign prod_ready = (state_q == ACCUM) || out_ready;
  assign prod_xfer  = prod_valid && prod_ready;

  always_comb begin
    sum    = acc_q + ACC_WIDTH'($signed(prod_data));
    s_ext  = RW'(sum) + HALF;
    r_full = s_ext >>> FRAC_SHIFT;
`ifdef ACC_REQUANT_SAT_EN
    if (r_full > OUT_MAX) begin
      narrow = OUT_WIDTH'(OUT_MAX);
      clamp  = 1'b1;
    end else if (r_full < OUT_MIN) begin
      narrow = OUT_WIDTH'(OUT_MIN);
      clamp  = 1'b1;
    end else begin
      narrow = OUT_WIDTH'(r_full);
      clamp  = 1'b0;
    end
`else
    narrow = OUT_WIDTH'(r_full);
    clamp  = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;

    // A pending result is consumed whenever out_ready is high in HOLD; a
    // last-term transfer below overrides this and re-enters HOLD, giving
    // back-to-back results without a bubble.
    if (state_q == HOLD && out_ready) begin
      state_d = ACCUM;
    end

    if (prod_xfer) begin
      if (cnt_q == CNT_LAST) begin
        out_data_d = narrow;
        ovf_d      = ovf_q | clamp;
        acc_d      = '0;
        cnt_d      = '0;
        state_d    = HOLD;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_example_acc_requant.sv
// tb_example_acc_requant
//   Directed self-checking bench for example_acc_requant (default parameters:
//   PROD_WIDTH=20, ACC_WIDTH=28, OUT_WIDTH=16, N_TERMS=8, FRAC_SHIFT=4).
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_example_acc_requant;

  logic        clk;
  logic        ap_rst_n;
  logic [19:0] prod_data;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;

  int checks;
  int failures;

  example_acc_requant #(
    .PROD_WIDTH(20),
    .ACC_WIDTH (28),
    .OUT_WIDTH (16),
    .N_TERMS   (8),
    .FRAC_SHIFT(4)
  ) dut (
    .ap_clk    (clk),
    .ap_rst_n  (ap_rst_n),
    .prod_data (prod_data),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one product for exactly one clock edge (caller guarantees
  // prod_ready is high), ending on the following falling edge.
  task automatic feed(input int v);
    prod_valid = 1'b1;
    prod_data  = 20'(v);
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (prod_ready !== 1'b1) begin
      failures++; $display("FAIL reset_prod_ready: got %b expected 1", prod_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 16'd0) begin
      failures++; $display("FAIL reset_out_data: got %0d expected 0", $signed(out_data));
    end
    checks++;
    if (ovf !== 1'b0) begin
      failures++; $display("FAIL reset_ovf: got %b expected 0", ovf);
    end
  endtask

  // 8 x +100 = 800; (800+8)>>4 = 50
  task automatic test_basic_group;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) feed(100);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_early_valid: got %b expected 0", out_valid);
    end
    feed(100);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL basic_valid: got %b expected 1", out_valid);
    end
    checks++;
    if (out_data !== 16'd50) begin
      failures++; $display("FAIL basic_data: got %0d expected 50", $signed(out_data));
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_pulse: got %b expected 0", out_valid);
    end
    checks++;
    if (ovf !== 1'b0) begin
      failures++; $display("FAIL basic_ovf: got %b expected 0", ovf);
    end
  endtask

  // +24 -> 2, -24 -> -1, 8 x -17 = -136 -> -8
  task automatic test_rounding;
    int          vals [3];
    logic [15:0] exp  [3];
    vals[0] = 3;   exp[0] = 16'd2;
    vals[1] = -3;  exp[1] = 16'hFFFF;
    vals[2] = -17; exp[2] = 16'hFFF8;
    out_ready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 8; i++) feed(vals[g]);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[g]) begin
        failures++;
        $display("FAIL rounding_group%0d: got valid=%b data=%0d expected valid=1 data=%0d",
                 g, out_valid, $signed(out_data), $signed(exp[g]));
      end
    end
    @(negedge clk);
  endtask

  // Stream stalls while a result is held; then 1..8 streams in on release.
  task automatic test_backpressure;
    int first_k;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) feed(100);
    out_ready  = 1'b0;
    prod_valid = 1'b1;
    prod_data  = 20'd7;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (prod_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'd50) begin
        failures++;
        $display("FAIL bp_hold_cycle%0d: got ready=%b valid=%b data=%0d expected ready=0 valid=1 data=50",
                 c, prod_ready, out_valid, $signed(out_data));
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    first_k   = 0;
    for (int k = 1; k <= 20; k++) begin
      prod_valid = 1'b1;
      prod_data  = 20'(k);
      @(negedge clk);
      if (out_valid) begin
        first_k = k;
        break;
      end
    end
    prod_valid = 1'b0;
    checks++;
    if (first_k != 8) begin
      failures++; $display("FAIL bp_latency: got %0d expected 8", first_k);
    end
    checks++;
    if (out_data !== 16'd2) begin
      failures++; $display("FAIL bp_data: got %0d expected 2", $signed(out_data));
    end
    @(negedge clk);
  endtask

  // 1..8 = 36 -> 2, 9..16 = 100 -> 6, no stall at the boundary
  task automatic test_back_to_back;
    int stalls;
    stalls    = 0;
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      prod_valid = 1'b1;
      prod_data  = 20'(k);
      #1;
      if (!prod_ready) stalls++;
      @(negedge clk);
      if (k == 8) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd2) begin
          failures++;
          $display("FAIL b2b_first: got valid=%b data=%0d expected valid=1 data=2",
                   out_valid, $signed(out_data));
        end
      end
      if (k == 9) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++; $display("FAIL b2b_pulse: got %b expected 0", out_valid);
        end
      end
    end
    prod_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd6) begin
      failures++;
      $display("FAIL b2b_second: got valid=%b data=%0d expected valid=1 data=6",
               out_valid, $signed(out_data));
    end
    checks++;
    if (stalls != 0) begin
      failures++; $display("FAIL b2b_stalls: got %0d expected 0", stalls);
    end
    @(negedge clk);
  endtask

  // 8 x 524287 = 4194296; (4194296+8)>>4 = 262144 = 0x40000
  task automatic test_saturation;
    logic [15:0] exp_data;
    logic        exp_ovf;
`ifdef ACC_REQUANT_SAT_EN
    exp_data = 16'h7FFF;
    exp_ovf  = 1'b1;
`else
    exp_data = 16'h0000;
    exp_ovf  = 1'b0;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) feed(524287);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_data) begin
      failures++;
      $display("FAIL sat_data: got valid=%b data=%0d expected valid=1 data=%0d",
               out_valid, $signed(out_data), $signed(exp_data));
    end
    checks++;
    if (ovf !== exp_ovf) begin
      failures++; $display("FAIL sat_ovf: got %b expected %b", ovf, exp_ovf);
    end
    for (int i = 0; i < 8; i++) feed(100);
    checks++;
    if (out_data !== 16'd50) begin
      failures++; $display("FAIL sat_next_data: got %0d expected 50", $signed(out_data));
    end
    checks++;
    if (ovf !== exp_ovf) begin
      failures++; $display("FAIL sat_ovf_sticky: got %b expected %b", ovf, exp_ovf);
    end
    @(negedge clk);
  endtask

  // Partial sum of 3 x 1000 must be discarded by reset; 8 x 16 -> 8
  task automatic test_reset_mid_group;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) feed(1000);
    out_ready = 1'b0;
    ap_rst_n  = 1'b0;
    #1;
    test_reset;
    @(negedge clk);
    ap_rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) feed(16);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_early_valid: got %b expected 0", out_valid);
    end
    feed(16);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd8) begin
      failures++;
      $display("FAIL rstmid_data: got valid=%b data=%0d expected valid=1 data=8",
               out_valid, $signed(out_data));
    end
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    ap_rst_n   = 1'b0;
    prod_valid = 1'b0;
    prod_data  = '0;
    out_ready  = 1'b0;
    #2;
    test_reset;
    @(negedge clk);
    ap_rst_n = 1'b1;
    @(negedge clk);
    test_basic_group;
    test_rounding;
    test_backpressure;
    test_back_to_back;
    test_saturation;
    test_reset_mid_group;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
